// File: rtl/q_table_updater.sv
// q_table_updater: Q-table row store with a 4-state temporal-difference update engine.
// Rev 1.0 - initial release.
`default_nettype none

module q_table_updater #(
  parameter int NUM_STATES  = 16,
  parameter int STATE_W     = 4,
  parameter int Q_W         = 16,
  parameter int ALPHA_SHIFT = 1,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] rd_state,
  output logic [4*Q_W-1:0]   q_values,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [STATE_W-1:0] upd_state,
  input  logic [3:0]         upd_action,
  input  logic [STATE_W-1:0] upd_next,
  input  logic [Q_W-1:0]     upd_reward,
  output logic               upd_done
);

  localparam int EXT_W = Q_W + 3;
  localparam logic [STATE_W:0]        c_NUM_STATES = NUM_STATES[STATE_W:0];
  localparam logic signed [EXT_W-1:0] c_QMAX = EXT_W'((2 ** (Q_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] c_QMIN = -EXT_W'(2 ** (Q_W - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAXQ  = 2'd1,
    S_CALC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t                    r_state;
  logic signed [Q_W-1:0]     r_table [NUM_STATES][4];
  logic [STATE_W-1:0]        r_s;
  logic [3:0]                r_a;
  logic [STATE_W-1:0]        r_sn;
  logic signed [Q_W-1:0]     r_r;
  logic signed [Q_W-1:0]     r_maxq;
  logic signed [Q_W-1:0]     r_qcur;
  logic signed [Q_W-1:0]     r_qnew;
  logic [1:0]                r_lane;
  logic [4*Q_W-1:0]          r_q_values;
  logic                      r_done;

  logic                      w_skip;
  logic                      w_rd_ok;
  logic                      w_sn_ok;
  logic [1:0]                w_lane;
  logic signed [Q_W-1:0]     w_maxq;
  logic signed [EXT_W-1:0]   w_r_x;
  logic signed [EXT_W-1:0]   w_maxq_x;
  logic signed [EXT_W-1:0]   w_qcur_x;
  logic signed [EXT_W-1:0]   w_target;
  logic signed [EXT_W-1:0]   w_delta;
  logic signed [EXT_W-1:0]   w_qnew_x;
  logic signed [Q_W-1:0]     w_qsat;

  assign upd_ready = (r_state == S_IDLE);
  assign q_values  = r_q_values;
  assign upd_done  = r_done;

  assign w_rd_ok = ({1'b0, rd_state} < c_NUM_STATES);
  assign w_sn_ok = ({1'b0, r_sn} < c_NUM_STATES);
  assign w_skip  = (r_a == 4'd0) || ({1'b0, r_s} >= c_NUM_STATES);

  // A multi-hot action resolves to its lowest set bit.
  always_comb begin
    w_lane = 2'd0;
    if (r_a[0])      w_lane = 2'd0;
    else if (r_a[1]) w_lane = 2'd1;
    else if (r_a[2]) w_lane = 2'd2;
    else if (r_a[3]) w_lane = 2'd3;
  end

  always_comb begin
    w_maxq = '0;
    if (w_sn_ok) begin
      w_maxq = r_table[r_sn][0];
      for (int i = 1; i < 4; i++) begin
        if (r_table[r_sn][i] > w_maxq) w_maxq = r_table[r_sn][i];
      end
    end
  end

  // gamma*maxq is formed as maxq - maxq/2^G; the 3 guard bits keep every term exact.
  assign w_r_x    = {{3{r_r[Q_W-1]}}, r_r};
  assign w_maxq_x = {{3{r_maxq[Q_W-1]}}, r_maxq};
  assign w_qcur_x = {{3{r_qcur[Q_W-1]}}, r_qcur};
  assign w_target = w_r_x + w_maxq_x - (w_maxq_x >>> GAMMA_SHIFT);
  assign w_delta  = w_target - w_qcur_x;
  assign w_qnew_x = w_qcur_x + (w_delta >>> ALPHA_SHIFT);

  always_comb begin
    w_qsat = w_qnew_x[Q_W-1:0];
    if (w_qnew_x > c_QMAX)      w_qsat = c_QMAX[Q_W-1:0];
    else if (w_qnew_x < c_QMIN) w_qsat = c_QMIN[Q_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_s        <= '0;
      r_a        <= '0;
      r_sn       <= '0;
      r_r        <= '0;
      r_maxq     <= '0;
      r_qcur     <= '0;
      r_qnew     <= '0;
      r_lane     <= '0;
      r_q_values <= '0;
      r_done     <= 1'b0;
      for (int s = 0; s < NUM_STATES; s++) begin
        for (int a = 0; a < 4; a++) begin
          r_table[s][a] <= '0;
        end
      end
    end else begin
      // Non-blocking read gives read-before-write against a same-edge table update.
      if (w_rd_ok) begin
        r_q_values <= {r_table[rd_state][3], r_table[rd_state][2],
                       r_table[rd_state][1], r_table[rd_state][0]};
      end else begin
        r_q_values <= '0;
      end
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (upd_valid) begin
            r_s     <= upd_state;
            r_a     <= upd_action;
            r_sn    <= upd_next;
            r_r     <= upd_reward;
            r_state <= S_MAXQ;
          end
        end
        S_MAXQ: begin
          r_maxq <= w_maxq;
          r_lane <= w_lane;
          r_qcur <= w_skip ? '0 : r_table[r_s][w_lane];
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_qnew  <= w_qsat;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (!w_skip) r_table[r_s][r_lane] <= r_qnew;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_q_table_updater.sv
// tb_q_table_updater: directed vector table, hand sequences and random updates against a Q-learning model.
`default_nettype none

module tb_q_table_updater;

  localparam int NS = 16;
  localparam int ALPHA = 1;
  localparam int GAMMA = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_state;
  logic [63:0] q_values;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  upd_state;
  logic [3:0]  upd_action;
  logic [3:0]  upd_next;
  logic [15:0] upd_reward;
  logic        upd_done;

  int n_vec = 0;
  int n_bad = 0;
  int mdl [NS][4];

  always #5 clk = ~clk;

  q_table_updater #(
    .NUM_STATES(NS), .STATE_W(4), .Q_W(16), .ALPHA_SHIFT(ALPHA), .GAMMA_SHIFT(GAMMA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_state(rd_state), .q_values(q_values),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_state(upd_state),
    .upd_action(upd_action), .upd_next(upd_next), .upd_reward(upd_reward),
    .upd_done(upd_done)
  );

  typedef struct {
    logic [3:0] s;
    logic [3:0] a;
    logic [3:0] sn;
    int         r;
    int         lane;
    int         exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int fl(input int x, input int d);
    int q;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [63:0] mrow(input int s);
    logic [63:0] row;
    int v;
    for (int i = 0; i < 4; i++) begin
      v = mdl[s][i];
      row[16*i +: 16] = v[15:0];
    end
    return row;
  endfunction

  // Reference Q-learning step: Q += alpha*(r + gamma*maxQ(s') - Q), clamped to 16 bits.
  task automatic model_apply(input int s, input logic [3:0] a, input int sn, input int r);
    int lane, mx, t, d, qn;
    if (a == 4'd0 || s >= NS) return;
    lane = 0;
    while (!a[lane]) lane++;
    mx = 0;
    if (sn < NS) begin
      mx = mdl[sn][0];
      for (int i = 1; i < 4; i++) if (mdl[sn][i] > mx) mx = mdl[sn][i];
    end
    t  = r + mx - fl(mx, 1 << GAMMA);
    d  = t - mdl[s][lane];
    qn = mdl[s][lane] + fl(d, 1 << ALPHA);
    if (qn > 32767) qn = 32767;
    if (qn < -32768) qn = -32768;
    mdl[s][lane] = qn;
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++) for (int i = 0; i < 4; i++) mdl[s][i] = 0;
  endtask

  // Called at posedge+1 with the engine idle; returns at posedge+1 of the upd_done cycle.
  task automatic do_upd(input logic [3:0] s, input logic [3:0] a, input logic [3:0] sn, input int r);
    int lat;
    chk("ready_before", {63'd0, upd_ready}, 64'd1);
    upd_state  = s;
    upd_action = a;
    upd_next   = sn;
    upd_reward = r[15:0];
    upd_valid  = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    lat = 0;
    while (!upd_done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", 64'(lat), 64'd3);
    chk("ready_after", {63'd0, upd_ready}, 64'd1);
    model_apply(int'(s), a, int'(sn), r);
  endtask

  task automatic read_row(input int s, output logic [63:0] row);
    rd_state = s[3:0];
    @(posedge clk); #1;
    row = q_values;
  endtask

  initial begin
    vec_t        vt [10];
    logic [63:0] row;
    int          v, r, dones;
    int          acc [$];

    vt[0] = '{4'd2, 4'b0001, 4'd3,  100,   0, 50};
    vt[1] = '{4'd3, 4'b0010, 4'd15, 160,   1, 80};
    vt[2] = '{4'd2, 4'b0001, 4'd3,  100,   0, 110};
    vt[3] = '{4'd4, 4'b0001, 4'd14, -3,    0, -2};
    vt[4] = '{4'd6, 4'b0000, 4'd2,  500,   0, 0};
    vt[5] = '{4'd7, 4'b0110, 4'd2,  20,    1, 58};
    vt[6] = '{4'd5, 4'b1000, 4'd5,  32767, 3, 16383};
    vt[7] = '{4'd5, 4'b1000, 4'd5,  32767, 3, 31743};
    vt[8] = '{4'd5, 4'b1000, 4'd5,  32767, 3, 32767};
    vt[9] = '{4'd5, 4'b1000, 4'd5,  32767, 3, 32767};

    model_clear();
    rst_n = 1'b0; rd_state = '0; upd_valid = 1'b0;
    upd_state = '0; upd_action = '0; upd_next = '0; upd_reward = '0;
    #12;
    chk("reset_ready", {63'd0, upd_ready}, 64'd1);
    chk("reset_done", {63'd0, upd_done}, 64'd0);
    chk("reset_qv", q_values, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NS; i++) begin
      read_row(i, row);
      chk($sformatf("reset_row%0d", i), row, 64'd0);
    end

    for (int k = 0; k < 10; k++) begin
      do_upd(vt[k].s, vt[k].a, vt[k].sn, vt[k].r);
      read_row(int'(vt[k].s), row);
      v = vt[k].exp;
      chk($sformatf("vec%0d_lane", k), {48'd0, row[16*vt[k].lane +: 16]}, {48'd0, v[15:0]});
      chk($sformatf("vec%0d_row", k), row, mrow(int'(vt[k].s)));
    end

    // upd_valid stays high; the second request is presented only after the first is taken.
    upd_state = 4'd10; upd_action = 4'b0001; upd_next = 4'd11; upd_reward = 16'd1000;
    upd_valid = 1'b1;
    dones = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      logic rdy;
      rdy = upd_ready;
      @(posedge clk);
      if (rdy && upd_valid) acc.push_back(cyc);
      #1;
      if (upd_done) dones++;
      if (acc.size() == 1 && acc[0] == cyc) begin
        upd_state = 4'd10; upd_action = 4'b0100; upd_next = 4'd10; upd_reward = -16'sd200;
      end
      if (acc.size() == 2) upd_valid = 1'b0;
    end
    chk("b2b_accepts", 64'(acc.size()), 64'd2);
    if (acc.size() == 2) chk("b2b_gap", 64'(acc[1] - acc[0]), 64'd4);
    chk("b2b_dones", 64'(dones), 64'd2);
    model_apply(10, 4'b0001, 11, 1000);
    model_apply(10, 4'b0100, 10, -200);
    read_row(10, row);
    chk("b2b_row10", row, mrow(10));

    // Reset asserted while the engine sits in CALC.
    upd_state = 4'd1; upd_action = 4'b0001; upd_next = 4'd1; upd_reward = 16'd1000;
    upd_valid = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_ready", {63'd0, upd_ready}, 64'd1);
    chk("midrst_done", {63'd0, upd_done}, 64'd0);
    chk("midrst_qv", q_values, 64'd0);
    model_clear();
    #10 rst_n = 1'b1;
    #1;
    chk("midrst_ready_rel", {63'd0, upd_ready}, 64'd1);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (upd_done) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    for (int i = 0; i < NS; i++) begin
      read_row(i, row);
      chk($sformatf("midrst_row%0d", i), row, mrow(i));
    end

    for (int k = 0; k < 40; k++) begin
      logic [3:0] s, a, sn;
      s  = 4'($urandom_range(0, 15));
      a  = 4'($urandom_range(0, 15));
      sn = ($urandom_range(0, 3) == 0) ? s : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       r = 32767;
        1:       r = -32768;
        default: r = int'($urandom_range(0, 8000)) - 4000;
      endcase
      do_upd(s, a, sn, r);
      read_row(int'(s), row);
      chk($sformatf("rnd%0d_row%0d", k, s), row, mrow(int'(s)));
      v = int'($urandom_range(0, 15));
      read_row(v, row);
      chk($sformatf("rnd%0d_peek%0d", k, v), row, mrow(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
